// File: rtl/show_text_box.sv
// Multi-line text box renderer for the VGA overlay: writable character buffer,
// SCALE x SCALE glyph magnification and a blinking block cursor.

module characters (
  input  logic [7:0] code,
  input  logic [2:0] col,
  input  logic [2:0] row,
  output logic       pixel
);
  logic [4:0] bits;

  // 5x8 glyphs, bit 4 is the leftmost column; column 5 is always blank
  always_comb begin
    bits = 5'b00000;
    case (code)
      8'h41: begin
        case (row)
          3'd0:                  bits = 5'b01110;
          3'd3:                  bits = 5'b11111;
          3'd7:                  bits = 5'b00000;
          default:               bits = 5'b10001;
        endcase
      end
      8'h42: begin
        case (row)
          3'd0, 3'd3, 3'd6:      bits = 5'b11110;
          3'd7:                  bits = 5'b00000;
          default:               bits = 5'b10001;
        endcase
      end
      8'h30: begin
        case (row)
          3'd0, 3'd6:            bits = 5'b01110;
          3'd2:                  bits = 5'b10011;
          3'd3:                  bits = 5'b10101;
          3'd4:                  bits = 5'b11001;
          3'd7:                  bits = 5'b00000;
          default:               bits = 5'b10001;
        endcase
      end
      default:                   bits = 5'b00000;
    endcase
    pixel = (col < 3'd5) ? bits[3'd4 - col] : 1'b0;
  end
endmodule

module show_text_box #(
  parameter logic [10:0] CHAR_X_LOC         = 11'd70,
  parameter logic [10:0] CHAR_Y_LOC         = 11'd150,
  parameter int          SCALE              = 3,
  parameter int          MAX_CHARACTER_LINE = 16,
  parameter int          MAX_NUMBER_LINES   = 2,
  parameter int          BLINK_FRAMES       = 30,
  localparam int         DEPTH              = MAX_CHARACTER_LINE * MAX_NUMBER_LINES,
  localparam int         AW                 = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [10:0]   hc_visible,
  input  logic [10:0]   vc_visible,
  input  logic          frame_start,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  input  logic          cursor_en,
  input  logic [AW-1:0] cursor_pos,
  output logic          in_square,
  output logic          in_character
);
  localparam int BOX_W = 6 * MAX_CHARACTER_LINE * SCALE + SCALE;
  localparam int BOX_H = 8 * MAX_NUMBER_LINES * SCALE + SCALE;
  localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int CW    = (MAX_CHARACTER_LINE > 1) ? $clog2(MAX_CHARACTER_LINE) : 1;
  localparam int LW    = (MAX_NUMBER_LINES > 1) ? $clog2(MAX_NUMBER_LINES) : 1;
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [11:0] X_END  = {1'b0, CHAR_X_LOC} + 12'(BOX_W);
  localparam logic [11:0] Y_END  = {1'b0, CHAR_Y_LOC} + 12'(BOX_H);
  localparam logic [10:0] X_LAST = 11'(X_END - 12'd1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_ptr, clr_ptr_nxt;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [7:0]      mem_wdata;
  logic [7:0]      text_mem [DEPTH];

  logic [BW-1:0]   fcnt;
  logic            blink;

  logic            h_mar_r, h_mar_p0;
  logic [SW-1:0]   h_sub_r, h_sub_p0;
  logic [2:0]      h_gx_r, h_gx_p0;
  logic [CW-1:0]   h_cell_r, h_cell_p0;
  logic            v_mar_r, v_mar_p0;
  logic [SW-1:0]   v_sub_r, v_sub_p0;
  logic [2:0]      v_gy_r, v_gy_p0;
  logic [LW-1:0]   v_line_r, v_line_p0;

  logic            inbox_x_p0, inbox_y_p0, inbox_p0, text_p0, v_adv_p0;
  logic [AW-1:0]   rd_idx_p0;
  logic            pix_p0, cur_p0;
  logic            in_square_p1, in_character_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    mem_we      = 1'b0;
    mem_waddr   = wr_addr;
    mem_wdata   = wr_data;
    wr_ready    = 1'b0;
    case (state)
      S_CLEAR: begin
        mem_we      = 1'b1;
        mem_waddr   = clr_ptr;
        mem_wdata   = 8'h20;
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (int'(clr_ptr) == DEPTH - 1) state_nxt = S_IDLE;
      end
      default: begin
        wr_ready = 1'b1;
        if (wr_en && (int'(wr_addr) < DEPTH)) mem_we = 1'b1;
      end
    endcase
  end

  // Asynchronous read gives read-before-write against the edge-triggered write
  always_ff @(posedge clk) begin
    if (mem_we) text_mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt  <= '0;
      blink <= 1'b1;
    end else if (frame_start) begin
      if (int'(fcnt) == BLINK_FRAMES - 1) begin
        fcnt  <= '0;
        blink <= ~blink;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Stage p0: counters restart on the box's first column/row, else follow the registered prediction
  always_comb begin
    h_mar_p0  = h_mar_r;
    h_sub_p0  = h_sub_r;
    h_gx_p0   = h_gx_r;
    h_cell_p0 = h_cell_r;
    if (hc_visible == CHAR_X_LOC) begin
      h_mar_p0  = 1'b1;
      h_sub_p0  = '0;
      h_gx_p0   = '0;
      h_cell_p0 = '0;
    end
    v_mar_p0  = v_mar_r;
    v_sub_p0  = v_sub_r;
    v_gy_p0   = v_gy_r;
    v_line_p0 = v_line_r;
    if (vc_visible == CHAR_Y_LOC) begin
      v_mar_p0  = 1'b1;
      v_sub_p0  = '0;
      v_gy_p0   = '0;
      v_line_p0 = '0;
    end
  end

  always_ff @(posedge clk) begin
    h_mar_r  <= h_mar_p0;
    h_sub_r  <= h_sub_p0 + 1'b1;
    h_gx_r   <= h_gx_p0;
    h_cell_r <= h_cell_p0;
    if (int'(h_sub_p0) == SCALE - 1) begin
      h_sub_r <= '0;
      if (h_mar_p0) begin
        h_mar_r  <= 1'b0;
        h_gx_r   <= '0;
        h_cell_r <= '0;
      end else if (h_gx_p0 == 3'd5) begin
        h_gx_r <= '0;
        if (int'(h_cell_p0) != MAX_CHARACTER_LINE - 1) h_cell_r <= h_cell_p0 + 1'b1;
      end else begin
        h_gx_r <= h_gx_p0 + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (v_adv_p0) begin
      v_mar_r  <= v_mar_p0;
      v_sub_r  <= v_sub_p0 + 1'b1;
      v_gy_r   <= v_gy_p0;
      v_line_r <= v_line_p0;
      if (int'(v_sub_p0) == SCALE - 1) begin
        v_sub_r <= '0;
        if (v_mar_p0) begin
          v_mar_r  <= 1'b0;
          v_gy_r   <= '0;
          v_line_r <= '0;
        end else begin
          v_gy_r <= v_gy_p0 + 3'd1;
          if (v_gy_p0 == 3'd7 && int'(v_line_p0) != MAX_NUMBER_LINES - 1)
            v_line_r <= v_line_p0 + 1'b1;
        end
      end
    end
  end

  assign inbox_x_p0 = (hc_visible >= CHAR_X_LOC) && ({1'b0, hc_visible} < X_END);
  assign inbox_y_p0 = (vc_visible >= CHAR_Y_LOC) && ({1'b0, vc_visible} < Y_END);
  assign inbox_p0   = inbox_x_p0 && inbox_y_p0;
  assign v_adv_p0   = inbox_y_p0 && (hc_visible == X_LAST);
  assign text_p0    = inbox_p0 && !h_mar_p0 && !v_mar_p0;
  assign rd_idx_p0  = AW'(int'(v_line_p0) * MAX_CHARACTER_LINE + int'(h_cell_p0));
  assign cur_p0     = cursor_en && blink && (rd_idx_p0 == cursor_pos);

  characters u_glyph (
    .code  (text_mem[rd_idx_p0]),
    .col   (h_gx_p0),
    .row   (v_gy_p0),
    .pixel (pix_p0)
  );

  // Stage p1: registered outputs for the colour mux
  always_ff @(posedge clk) begin
    if (rst) begin
      in_square_p1    <= 1'b0;
      in_character_p1 <= 1'b0;
    end else begin
      in_square_p1    <= inbox_p0;
      in_character_p1 <= text_p0 && (h_gx_p0 != 3'd5) && (pix_p0 ^ cur_p0);
    end
  end

  assign in_square    = in_square_p1;
  assign in_character = in_character_p1;
endmodule

// File: tb/tb_show_text_box.sv
// Directed bench for show_text_box: scanned frames compared against a
// geometric reference plus a table of hand-computed pixel vectors.

module tb_show_text_box;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst, frame_start, wr_en, cursor_en;
  logic        wr_ready, in_square, in_character;
  logic [10:0] hc, vc;
  logic [4:0]  wr_addr, cursor_pos;
  logic [7:0]  wr_data;

  always #5 clk = ~clk;

  show_text_box dut (
    .clk          (clk),
    .rst          (rst),
    .hc_visible   (hc),
    .vc_visible   (vc),
    .frame_start  (frame_start),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .cursor_en    (cursor_en),
    .cursor_pos   (cursor_pos),
    .in_square    (in_square),
    .in_character (in_character)
  );

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] shadow [DEPTH];
  logic [4:0] a_rows [8];
  bit         m_blink;
  int         m_fcnt;
  bit         m_cur_en;
  int         m_cur_pos;
  bit         cap_sq [148:202][68:362];
  bit         cap_ch [148:202][68:362];

  typedef struct {
    int scan;
    int hc;
    int vc;
    bit sq;
    bit ch;
  } vec_t;
  vec_t vecs [$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  function automatic void add(input int s, input int h, input int v, input bit sq, input bit ch);
    vec_t e;
    e.scan = s; e.hc = h; e.vc = v; e.sq = sq; e.ch = ch;
    vecs.push_back(e);
  endfunction

  function automatic bit glyph(input logic [7:0] code, input int gx, input int gy);
    logic [4:0] r;
    if (code != 8'h41) return 1'b0;
    r = a_rows[gy];
    return r[4-gx];
  endfunction

  function automatic void model(input int h, input int v, output bit sq, output bit ch);
    int rx, ry, col, row, idx, gx, gy;
    bit cur;
    rx = h - 70;
    ry = v - 150;
    sq = (rx >= 0) && (rx < 291) && (ry >= 0) && (ry < 51);
    ch = 1'b0;
    if (sq && rx >= 3 && ry >= 3) begin
      col = (rx - 3) / 3;
      row = (ry - 3) / 3;
      gx  = col % 6;
      gy  = row % 8;
      idx = (row / 8) * 16 + col / 6;
      cur = m_cur_en && m_blink && (idx == m_cur_pos);
      if (gx != 5) ch = glyph(shadow[idx], gx, gy) ^ cur;
    end
  endfunction

  task automatic scan(input int sid, input int v0, input int v1, input bit do_wr,
                      input int wh, input int wv, input int waddr, input logic [7:0] wdat);
    int    errs  = 0;
    string first = "none";
    bit    esq, ech, hit;
    for (int v = v0; v <= v1; v++) begin
      for (int h = 68; h <= 362; h++) begin
        hc  = 11'(h);
        vc  = 11'(v);
        hit = do_wr && (h == wh) && (v == wv);
        if (hit) begin
          wr_en = 1'b1; wr_addr = 5'(waddr); wr_data = wdat;
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        model(h, v, esq, ech);
        cap_sq[v][h] = in_square;
        cap_ch[v][h] = in_character;
        if (in_square !== esq || in_character !== ech) begin
          if (errs == 0)
            first = $sformatf("(%0d,%0d) sq=%b ch=%b want %b %b", h, v, in_square, in_character, esq, ech);
          errs++;
        end
        if (hit) shadow[waddr] = wdat;
      end
    end
    hc = '0;
    vc = '0;
    chk($sformatf("scan%0d pixel errors, first %s", sid, first), errs, 0);
    foreach (vecs[i]) begin
      if (vecs[i].scan == sid) begin
        chk($sformatf("scan%0d in_square at (%0d,%0d)", sid, vecs[i].hc, vecs[i].vc),
            int'(cap_sq[vecs[i].vc][vecs[i].hc]), int'(vecs[i].sq));
        chk($sformatf("scan%0d in_character at (%0d,%0d)", sid, vecs[i].hc, vecs[i].vc),
            int'(cap_ch[vecs[i].vc][vecs[i].hc]), int'(vecs[i].ch));
      end
    end
  endtask

  task automatic do_reset(input bit busy_wr);
    int n = 0;
    rst = 1'b1; hc = 11'd200; vc = 11'd170; wr_en = 1'b0; frame_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset in_square", int'(in_square), 0);
    chk("reset in_character", int'(in_character), 0);
    chk("reset wr_ready", int'(wr_ready), 0);
    rst = 1'b0;
    while (wr_ready !== 1'b1 && n < 100) begin
      if (busy_wr && n == 3) begin
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'h41;
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      n++;
    end
    chk("wr_ready busy cycles after reset", n, 32);
    hc = '0;
    vc = '0;
    foreach (shadow[i]) shadow[i] = 8'h20;
    m_blink = 1'b1;
    m_fcnt  = 0;
  endtask

  task automatic write_cell(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    shadow[a] = d;
  endtask

  task automatic pulses(input int k);
    repeat (k) begin
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      @(posedge clk); #1;
      m_fcnt++;
      if (m_fcnt == 30) begin
        m_fcnt  = 0;
        m_blink = !m_blink;
      end
    end
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cursor_en = 1'b0; cursor_pos = '0; hc = '0; vc = '0;
    a_rows = '{5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b00000};
    m_cur_en = 1'b0; m_cur_pos = 0; m_blink = 1'b1; m_fcnt = 0;

    add(1, 70, 150, 1, 0);  add(1, 69, 150, 0, 0);  add(1, 360, 200, 1, 0);
    add(1, 361, 200, 0, 0); add(1, 70, 201, 0, 0);  add(1, 200, 149, 0, 0);
    add(1, 200, 175, 1, 0);
    add(2, 73, 153, 1, 0);  add(2, 76, 153, 1, 1);  add(2, 78, 155, 1, 1);
    add(2, 82, 153, 1, 1);  add(2, 85, 153, 1, 0);  add(2, 73, 162, 1, 1);
    add(2, 87, 164, 1, 1);  add(2, 88, 162, 1, 0);  add(2, 72, 160, 1, 0);
    add(2, 73, 174, 1, 0);  add(2, 91, 177, 1, 0);  add(2, 94, 177, 1, 1);
    add(2, 105, 188, 1, 1); add(2, 106, 186, 1, 0); add(2, 91, 162, 1, 0);
    add(2, 73, 186, 1, 0);  add(2, 109, 153, 1, 1); add(2, 123, 176, 1, 1);
    add(2, 124, 160, 1, 0); add(2, 108, 160, 1, 0); add(2, 109, 177, 1, 0);
    add(2, 109, 150, 1, 0);
    add(3, 109, 153, 1, 1); add(3, 76, 153, 1, 1);
    add(4, 109, 153, 1, 0); add(4, 123, 176, 1, 0); add(4, 76, 153, 1, 1);
    add(4, 115, 165, 1, 0);
    add(5, 109, 153, 1, 1); add(5, 115, 165, 1, 1);
    add(6, 76, 153, 1, 0);  add(6, 77, 153, 1, 1);  add(6, 73, 162, 1, 1);
    add(6, 88, 162, 1, 0);

    do_reset(1'b0);
    scan(1, 148, 202, 1'b0, 0, 0, 0, 8'h00);

    write_cell(0, 8'h41);
    write_cell(17, 8'h41);
    cursor_en = 1'b1; cursor_pos = 5'd2; m_cur_en = 1'b1; m_cur_pos = 2;
    scan(2, 148, 202, 1'b0, 0, 0, 0, 8'h00);

    pulses(29);
    scan(3, 150, 153, 1'b0, 0, 0, 0, 8'h00);
    pulses(1);
    scan(4, 150, 176, 1'b0, 0, 0, 0, 8'h00);
    pulses(30);
    scan(5, 150, 176, 1'b0, 0, 0, 0, 8'h00);

    cursor_en = 1'b0; m_cur_en = 1'b0;
    do_reset(1'b1);
    scan(6, 150, 176, 1'b1, 76, 153, 0, 8'h41);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
